// File: rtl/spi_mem_responder_if.sv
// SPI link and backdoor load port between the initiator side and the memory responder.
interface spi_mem_responder_if #(
    parameter int ADDR_BITS = 10
);
    logic                 spi_select;
    logic                 spi_in;
    logic                 spi_out;
    logic                 load_en;
    logic [ADDR_BITS-1:0] load_addr;
    logic [7:0]           load_data;
    logic                 busy;

    modport master (
        output spi_select, spi_in, load_en, load_addr, load_data,
        input  spi_out, busy
    );

    modport slave (
        input  spi_select, spi_in, load_en, load_addr, load_data,
        output spi_out, busy
    );
endinterface

// File: rtl/spi_mem_responder.sv
// On-chip serial memory answering the CPU instruction-fetch SPI link.
// One SPI bit per clk; read data starts the cycle after the last address bit.
//
// state   | meaning
// IDLE    | deselected, spi_out low
// CMD     | shifting in the 8-bit command, MSB first
// ADDR    | shifting in 24 address bits, only the low ADDR_BITS kept
// READ    | streaming bytes out, address auto-increments with wrap
// WRITE   | shifting bytes in, each completed byte written to memory
// IGNORE  | unknown command, hold spi_out low until deselect
module spi_mem_responder #(
    parameter int ADDR_BITS = 10,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rstn,
    spi_mem_responder_if.slave   bus
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_READ   = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;

    localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    logic [7:0] mem [2**ADDR_BITS];

    logic [2:0]           state_q, state_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic [6:0]           cmd_q, cmd_d;
    logic                 is_wr_q, is_wr_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           wbyte_q, wbyte_d;
    logic                 spi_out_q, spi_out_d;
    logic                 busy_q, busy_d;
    logic                 mem_we;
    logic [7:0]           cmd_full;

    logic [ADDR_BITS-1:0] addr_shift;
    logic [ADDR_BITS-1:0] addr_inc;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [7:0]           rd_byte;
    logic                 rd_first_bit;
    logic [7:0]           rd_rest;
    logic                 sh_next_bit;
    logic [7:0]           sh_rest;
    logic [7:0]           wbyte_shift;

    // Fetch path: the first byte uses the address completed this edge, later bytes the next address.
    assign addr_shift   = {addr_q[ADDR_BITS-2:0], bus.spi_in};
    assign addr_inc     = addr_q + ADDR_ONE;
    assign rd_addr      = (state_q == ST_ADDR) ? addr_shift : addr_inc;
    assign rd_byte      = mem[rd_addr];
    assign rd_first_bit = LSB_FIRST ? rd_byte[0] : rd_byte[7];
    assign rd_rest      = LSB_FIRST ? {1'b0, rd_byte[7:1]} : {rd_byte[6:0], 1'b0};
    assign sh_next_bit  = LSB_FIRST ? shift_q[0] : shift_q[7];
    assign sh_rest      = LSB_FIRST ? {1'b0, shift_q[7:1]} : {shift_q[6:0], 1'b0};
    assign wbyte_shift  = LSB_FIRST ? {bus.spi_in, wbyte_q[7:1]} : {wbyte_q[6:0], bus.spi_in};
    assign cmd_full     = {cmd_q, bus.spi_in};

    // Next-state logic; deselect overrides everything at the end.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        cmd_d     = cmd_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        shift_d   = shift_q;
        wbyte_d   = wbyte_q;
        spi_out_d = 1'b0;
        mem_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_d     = {6'd0, bus.spi_in};
                bit_cnt_d = 5'd1;
                state_d   = ST_CMD;
            end
            ST_CMD: begin
                cmd_d = cmd_full[6:0];
                if (bit_cnt_q == 5'd7) begin
                    bit_cnt_d = 5'd0;
                    if (cmd_full == 8'h03) begin
                        is_wr_d = 1'b0;
                        state_d = ST_ADDR;
                    end else if (cmd_full == 8'h02) begin
                        is_wr_d = 1'b1;
                        state_d = ST_ADDR;
                    end else begin
                        state_d = ST_IGNORE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end
            ST_ADDR: begin
                addr_d = addr_shift;
                if (bit_cnt_q == 5'd23) begin
                    if (is_wr_q) begin
                        bit_cnt_d = 5'd0;
                        state_d   = ST_WRITE;
                    end else begin
                        spi_out_d = rd_first_bit;
                        shift_d   = rd_rest;
                        bit_cnt_d = 5'd1;
                        state_d   = ST_READ;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end
            ST_READ: begin
                if (bit_cnt_q == 5'd8) begin
                    addr_d    = addr_inc;
                    spi_out_d = rd_first_bit;
                    shift_d   = rd_rest;
                    bit_cnt_d = 5'd1;
                end else begin
                    spi_out_d = sh_next_bit;
                    shift_d   = sh_rest;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end
            ST_WRITE: begin
                wbyte_d = wbyte_shift;
                if (bit_cnt_q == 5'd7) begin
                    mem_we    = 1'b1;
                    addr_d    = addr_inc;
                    bit_cnt_d = 5'd0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end
            ST_IGNORE: begin
                spi_out_d = 1'b0;
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = 5'd0;
            end
        endcase

        if (bus.spi_select) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 5'd0;
            spi_out_d = 1'b0;
            mem_we    = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 5'd0;
            cmd_q     <= 7'd0;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            shift_q   <= 8'd0;
            wbyte_q   <= 8'd0;
            spi_out_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            cmd_q     <= cmd_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            shift_q   <= shift_d;
            wbyte_q   <= wbyte_d;
            spi_out_q <= spi_out_d;
            busy_q    <= busy_d;
        end
    end

    // Memory writes: a backdoor load to the same address as a completing SPI byte wins.
    always_ff @(posedge clk) begin
        if (rstn && mem_we && !(bus.load_en && (bus.load_addr == addr_q))) begin
            mem[addr_q] <= wbyte_d;
        end
        if (bus.load_en) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    assign bus.spi_out = spi_out_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed bench for spi_mem_responder: inputs change 1 ns after a rising edge,
// outputs are sampled 1 ns after the edge that registered them.
module tb_spi_mem_responder;
    localparam int AB = 10;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   tests = 0;
    int   fails = 0;

    spi_mem_responder_if #(.ADDR_BITS(AB)) bus ();

    spi_mem_responder #(.ADDR_BITS(AB), .LSB_FIRST(1'b1)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.spi_select = 1'b0;
        bus.spi_in     = b;
        step();
    endtask

    task automatic send_byte_msb(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_byte_lsb(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 23; i >= 0; i--) send_bit(a[i]);
    endtask

    task automatic deselect();
        bus.spi_select = 1'b1;
        bus.spi_in     = 1'b0;
        step();
    endtask

    task automatic load(input logic [AB-1:0] a, input logic [7:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        step();
        bus.load_en   = 1'b0;
    endtask

    // Issue a read and collect nbits, stored LSB-first from bit 0 upward.
    task automatic spi_read(input logic [23:0] a, input int nbits, output logic [31:0] val);
        val = 32'd0;
        send_byte_msb(8'h03);
        send_addr(a);
        for (int j = 0; j < nbits; j++) begin
            val[j] = bus.spi_out;
            send_bit(1'b0);
        end
    endtask

    logic [31:0] rd;
    logic [31:0] cpu_sr;
    logic        or_out;

    initial begin
        bus.spi_select = 1'b1;
        bus.spi_in     = 1'b0;
        bus.load_en    = 1'b0;
        bus.load_addr  = '0;
        bus.load_data  = 8'd0;
        rstn = 1'b0;
        step();
        step();
        check("reset_spi_out", {31'd0, bus.spi_out}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        rstn = 1'b1;
        step();

        // Read of a little-endian word through a CPU-style right shift register.
        load(10'd0, 8'h13);
        load(10'd1, 8'h00);
        load(10'd2, 8'h00);
        load(10'd3, 8'h00);
        send_byte_msb(8'h03);
        send_addr(24'h000000);
        check("t1_busy", {31'd0, bus.busy}, 32'd1);
        cpu_sr = 32'd0;
        for (int j = 0; j < 32; j++) begin
            cpu_sr = {bus.spi_out, cpu_sr[31:1]};
            send_bit(1'b0);
        end
        check("t1_word", cpu_sr, 32'h0000_0013);
        deselect();

        // Address wrap with upper address bits ignored.
        load(10'h3FF, 8'hA5);
        load(10'h000, 8'h3C);
        load(10'h012, 8'h77);
        spi_read(24'hFFFFFF, 16, rd);
        deselect();
        check("t2_byte_top", {24'd0, rd[7:0]}, 32'h0000_00A5);
        check("t2_byte_wrap", {24'd0, rd[15:8]}, 32'h0000_003C);

        // Write two bytes, abort a third partway, read back over SPI.
        send_byte_msb(8'h02);
        send_addr(24'h000010);
        send_byte_lsb(8'hEF);
        send_byte_lsb(8'hBE);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        deselect();
        spi_read(24'h000010, 24, rd);
        deselect();
        check("t3_wr_0x10", {24'd0, rd[7:0]}, 32'h0000_00EF);
        check("t3_wr_0x11", {24'd0, rd[15:8]}, 32'h0000_00BE);
        check("t3_partial_0x12", {24'd0, rd[23:16]}, 32'h0000_0077);

        // Backdoor load lands on the same edge that completes an SPI byte write.
        send_byte_msb(8'h02);
        send_addr(24'h000020);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        bus.load_en   = 1'b1;
        bus.load_addr = 10'h020;
        bus.load_data = 8'h42;
        send_bit(1'b1);
        bus.load_en   = 1'b0;
        deselect();
        spi_read(24'h000020, 8, rd);
        deselect();
        check("collision_load_wins", {24'd0, rd[7:0]}, 32'h0000_0042);

        // Unknown command: output stays low, then a single IDLE cycle before a valid read.
        send_byte_msb(8'h9F);
        or_out = 1'b0;
        for (int i = 0; i < 40; i++) begin
            send_bit(1'b1);
            or_out = or_out | bus.spi_out;
        end
        check("t4_ignore_out", {31'd0, or_out}, 32'd0);
        check("t4_ignore_busy", {31'd0, bus.busy}, 32'd1);
        deselect();
        spi_read(24'h000010, 16, rd);
        deselect();
        check("t4_read_after", {16'd0, rd[15:0]}, 32'h0000_BEEF);

        // Abort partway through the address, then a full read of address 4.
        load(10'd4, 8'h5A);
        send_byte_msb(8'h03);
        for (int i = 0; i < 13; i++) send_bit(1'b0);
        check("t5_busy_abort", {31'd0, bus.busy}, 32'd1);
        deselect();
        check("t5_idle_abort", {31'd0, bus.busy}, 32'd0);
        spi_read(24'h000004, 8, rd);
        check("t5_busy_read", {31'd0, bus.busy}, 32'd1);
        deselect();
        check("t5_idle_read", {31'd0, bus.busy}, 32'd0);
        check("t5_mem4", {24'd0, rd[7:0]}, 32'h0000_005A);

        // Reset mid-read, then a clean read.
        spi_read(24'h0003FF, 4, rd);
        rstn = 1'b0;
        bus.spi_in = 1'b1;
        step();
        check("t6_rst_spi_out", {31'd0, bus.spi_out}, 32'd0);
        check("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
        rstn = 1'b1;
        deselect();
        spi_read(24'h0003FF, 16, rd);
        deselect();
        check("t6_read_after_rst", {16'd0, rd[15:0]}, 32'h0000_3CA5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
